// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - scoreboard entry and functional-unit opcodes seen at issue
package ariane_pkg;
  typedef enum logic [7:0] {
    ADD, SUB, ANDL, ORL, XORL, JALR, LD, SD, BEQ
  } fu_op;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    fu_op        op;
    logic [5:0]  rs1;
    logic [5:0]  rd;
    logic [63:0] result;
    exception_t  ex;
  } scoreboard_entry_t;
endpackage

// File: rtl/cfi_pkg.sv
// rtl/cfi_pkg.sv - shared types and register constants for the return-landing checker
package cfi_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } cfi_state_e;

  typedef struct packed {
    logic is_ret;
    logic is_mark;
    logic is_exc;
  } cfi_class_t;

  localparam logic [4:0] RA_REG   = 5'd1;
  localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - architectural exception causes used by the landing checker
package riscv;
  localparam logic [63:0] ILLEGAL_INSTR = 64'd2;
endpackage

// File: rtl/cfi_entry_classify.sv
// rtl/cfi_entry_classify.sv - classifies one scoreboard entry as return, marker or exception
module cfi_entry_classify
  import cfi_pkg::*;
#(
  parameter ariane_pkg::fu_op MARK_OP  = ariane_pkg::ADD,
  parameter logic [4:0]       MARK_RD  = 5'd0,
  parameter logic [4:0]       MARK_RS1 = 5'd0,
  parameter logic [4:0]       MARK_IMM = 5'd1
) (
  input  ariane_pkg::scoreboard_entry_t entry,
  output cfi_class_t                    cls
);

  // Only the low five bits of the immediate are part of the marker encoding.
  logic unused_bits;
  assign unused_bits = ^{entry.pc, entry.result[63:5], entry.ex.cause, entry.ex.tval};

  assign cls.is_exc  = entry.ex.valid;
  assign cls.is_ret  = !entry.ex.valid && (entry.op == ariane_pkg::JALR) &&
                       (entry.rd == {1'b0, ZERO_REG}) && (entry.rs1 == {1'b0, RA_REG});
  assign cls.is_mark = (entry.op == MARK_OP) && (entry.rd[4:0] == MARK_RD) &&
                       (entry.rs1[4:0] == MARK_RS1) && (entry.result[4:0] == MARK_IMM);

endmodule

// File: rtl/cfi_landing_checker.sv
// rtl/cfi_landing_checker.sv - flags returns not followed by a landing marker within WINDOW instructions
// Optional violation counter and PC capture enabled by CFI_VIOL_COUNTER_EN.
module cfi_landing_checker
  import cfi_pkg::*;
#(
  parameter int unsigned      NR_PORTS = 2,
  parameter int unsigned      WINDOW   = 1,
  parameter ariane_pkg::fu_op MARK_OP  = ariane_pkg::ADD,
  parameter logic [4:0]       MARK_RD  = 5'd0,
  parameter logic [4:0]       MARK_RS1 = 5'd0,
  parameter logic [4:0]       MARK_IMM = 5'd1,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic                                         clk_i,
  input  logic                                         rstn_i,
  input  logic                                         flush_i,
  input  logic                                         enable_i,
  input  logic [NR_PORTS-1:0]                          valid_i,
  input  logic [NR_PORTS-1:0]                          ack_i,
  input  ariane_pkg::scoreboard_entry_t [NR_PORTS-1:0] entry_i,
  output ariane_pkg::scoreboard_entry_t [NR_PORTS-1:0] entry_o,
  output logic                                         armed_o,
  output logic [CNT_W-1:0]                             viol_cnt_o,
  output logic [63:0]                                  viol_pc_o
);

  localparam int unsigned      REM_W    = $clog2(WINDOW + 1);
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(WINDOW);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

  cfi_class_t       cls [NR_PORTS];
  cfi_state_e       state_q, state_d, st;
  logic [REM_W-1:0] remain_q, remain_d, rem;
  logic             active, cons, hit;
  logic [63:0]      hit_pc;

  for (genvar k = 0; k < NR_PORTS; k++) begin : g_cls
    cfi_entry_classify #(
      .MARK_OP  (MARK_OP),
      .MARK_RD  (MARK_RD),
      .MARK_RS1 (MARK_RS1),
      .MARK_IMM (MARK_IMM)
    ) u_cls (
      .entry (entry_i[k]),
      .cls   (cls[k])
    );
  end

  // The window walks every presented entry so that a not-yet-accepted entry already
  // shows its flag; only the accepted prefix of ports commits the walked state.
  always_comb begin
    entry_o  = entry_i;
    state_d  = state_q;
    remain_d = remain_q;
    st       = state_q;
    rem      = remain_q;
    cons     = 1'b1;
    hit      = 1'b0;
    hit_pc   = '0;
    active   = enable_i && !flush_i && rstn_i;
    for (int k = 0; k < NR_PORTS; k++) begin
      cons = cons && valid_i[k] && ack_i[k];
      if (active && valid_i[k] && !cls[k].is_exc) begin
        if (st == IDLE) begin
          if (cls[k].is_ret) begin
            st  = ARMED;
            rem = REM_LOAD;
          end
        end else if (cls[k].is_mark) begin
          st  = IDLE;
          rem = '0;
        end else if (rem == REM_ONE) begin
          entry_o[k].ex.valid = 1'b1;
          entry_o[k].ex.cause = riscv::ILLEGAL_INSTR;
          entry_o[k].ex.tval  = '0;
          st  = IDLE;
          rem = '0;
          if (cons) begin
            hit    = 1'b1;
            hit_pc = entry_i[k].pc;
          end
        end else if (cls[k].is_ret) begin
          rem = REM_LOAD;
        end else begin
          rem = rem - REM_ONE;
        end
      end
      if (cons) begin
        state_d  = st;
        remain_d = rem;
      end
    end
    if (!active) begin
      state_d  = IDLE;
      remain_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  assign armed_o = (state_q == ARMED);

`ifdef CFI_VIOL_COUNTER_EN
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      pc_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      pc_q  <= '0;
    end else if (hit) begin
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      pc_q <= hit_pc;
    end
  end

  assign viol_cnt_o = cnt_q;
  assign viol_pc_o  = pc_q;
`else
  logic unused_hit;
  assign unused_hit = ^{hit, hit_pc};
  assign viol_cnt_o = '0;
  assign viol_pc_o  = '0;
`endif

endmodule

// File: tb/tb_cfi_landing_checker.sv
// tb/tb_cfi_landing_checker.sv - directed bench for the return-landing checker, WINDOW=1 and WINDOW=3
module tb_cfi_landing_checker;
  import ariane_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic a_flush, a_en, b_flush, b_en;
  logic [1:0] a_valid, a_ack, b_valid, b_ack;
  scoreboard_entry_t [1:0] a_in, a_out, b_in, b_out;
  logic a_armed, b_armed;
  logic [15:0] a_cnt, b_cnt;
  logic [63:0] a_pc, b_pc;

  int errors = 0;
  int checks = 0;
  int a_viol = 0, b_viol = 0;
  logic [63:0] a_last = '0, b_last = '0;
  scoreboard_entry_t e, x;

  cfi_landing_checker #(.NR_PORTS(2), .WINDOW(1)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .flush_i(a_flush), .enable_i(a_en),
    .valid_i(a_valid), .ack_i(a_ack), .entry_i(a_in), .entry_o(a_out),
    .armed_o(a_armed), .viol_cnt_o(a_cnt), .viol_pc_o(a_pc)
  );

  cfi_landing_checker #(.NR_PORTS(2), .WINDOW(3)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .flush_i(b_flush), .enable_i(b_en),
    .valid_i(b_valid), .ack_i(b_ack), .entry_i(b_in), .entry_o(b_out),
    .armed_o(b_armed), .viol_cnt_o(b_cnt), .viol_pc_o(b_pc)
  );

  function automatic scoreboard_entry_t mk(input logic [63:0] pc, input fu_op op,
                                           input logic [5:0] rd, input logic [5:0] rs1,
                                           input logic [63:0] imm);
    scoreboard_entry_t r;
    r = '0;
    r.pc = pc; r.op = op; r.rd = rd; r.rs1 = rs1; r.result = imm;
    return r;
  endfunction

  function automatic scoreboard_entry_t ret(input logic [63:0] pc);
    return mk(pc, JALR, 6'd0, 6'd1, 64'd0);
  endfunction
  function automatic scoreboard_entry_t mark(input logic [63:0] pc);
    return mk(pc, ADD, 6'd0, 6'd0, 64'd1);
  endfunction
  function automatic scoreboard_entry_t addi(input logic [63:0] pc);
    return mk(pc, ADD, 6'd5, 6'd0, 64'd7);
  endfunction
  function automatic scoreboard_entry_t flagged(input scoreboard_entry_t r);
    scoreboard_entry_t f;
    f = r;
    f.ex.valid = 1'b1; f.ex.cause = 64'd2; f.ex.tval = 64'd0;
    return f;
  endfunction

  function automatic logic [63:0] exp_cnt(input int v);
`ifdef CFI_VIOL_COUNTER_EN
    return (v > 65535) ? 64'd65535 : 64'(v);
`else
    return 64'd0;
`endif
  endfunction
  function automatic logic [63:0] exp_pc(input logic [63:0] pc);
`ifdef CFI_VIOL_COUNTER_EN
    return pc;
`else
    return 64'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_e(input string tag, input scoreboard_entry_t obs, input scoreboard_entry_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_set(input scoreboard_entry_t e0, input logic v0,
                       input scoreboard_entry_t e1, input logic v1, input logic [1:0] ack);
    a_in[0] = e0; a_in[1] = e1; a_valid = {v1, v0}; a_ack = ack;
    #1;
  endtask

  task automatic b_set(input scoreboard_entry_t e0, input logic v0,
                       input scoreboard_entry_t e1, input logic v1, input logic [1:0] ack);
    b_in[0] = e0; b_in[1] = e1; b_valid = {v1, v0}; b_ack = ack;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    a_flush = 1'b0; a_en = 1'b1; b_flush = 1'b0; b_en = 1'b1;
    b_set('0, 1'b0, '0, 1'b0, 2'b00);
    a_set(ret(64'h10), 1'b1, addi(64'h14), 1'b1, 2'b11);

    // reset: pass-through and cleared registers
    chk_e("rst_pass", a_out[1], addi(64'h14));
    repeat (2) tick();
    chk("rst_armed", 64'(a_armed), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_pc", a_pc, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    a_set('0, 1'b0, '0, 1'b0, 2'b00);
    tick();

    // return then marker: no flag
    a_set(ret(64'h100), 1'b1, '0, 1'b0, 2'b01);
    chk_e("t1_ret", a_out[0], ret(64'h100));
    tick();
    chk("t1_armed", 64'(a_armed), 64'd1);
    a_set(mark(64'h104), 1'b1, '0, 1'b0, 2'b01);
    chk_e("t1_mark", a_out[0], mark(64'h104));
    tick();
    chk("t1_disarm", 64'(a_armed), 64'd0);
    chk("t1_cnt", 64'(a_cnt), exp_cnt(a_viol));

    // return and non-marker in the same cycle
    a_set(ret(64'h200), 1'b1, addi(64'h204), 1'b1, 2'b11);
    chk_e("t2_p0", a_out[0], ret(64'h200));
    chk_e("t2_flag", a_out[1], flagged(addi(64'h204)));
    tick();
    a_viol++; a_last = 64'h204;
    chk("t2_armed", 64'(a_armed), 64'd0);
    chk("t2_cnt", 64'(a_cnt), exp_cnt(a_viol));
    chk("t2_pc", a_pc, exp_pc(a_last));

    // flush while armed
    a_set(ret(64'h300), 1'b1, '0, 1'b0, 2'b01);
    tick();
    chk("fl_armed", 64'(a_armed), 64'd1);
    a_flush = 1'b1;
    a_set(addi(64'h304), 1'b1, '0, 1'b0, 2'b01);
    chk_e("fl_noflag", a_out[0], addi(64'h304));
    tick();
    a_flush = 1'b0;
    chk("fl_idle", 64'(a_armed), 64'd0);
    a_set(addi(64'h308), 1'b1, '0, 1'b0, 2'b01);
    chk_e("fl_after", a_out[0], addi(64'h308));
    tick();

    // unacked marker holds the window open
    a_set(ret(64'h400), 1'b1, '0, 1'b0, 2'b01);
    tick();
    for (int i = 0; i < 5; i++) begin
      a_set(mark(64'h404), 1'b1, '0, 1'b0, 2'b00);
      chk_e("st_mark", a_out[0], mark(64'h404));
      tick();
      chk("st_armed", 64'(a_armed), 64'd1);
    end
    a_set(mark(64'h404), 1'b1, '0, 1'b0, 2'b01);
    chk_e("st_acked", a_out[0], mark(64'h404));
    tick();
    chk("st_idle", 64'(a_armed), 64'd0);

    // disabled: pure pass-through
    a_en = 1'b0;
    a_set(ret(64'h500), 1'b1, addi(64'h504), 1'b1, 2'b11);
    chk_e("dis_pass", a_out[1], addi(64'h504));
    tick();
    chk("dis_idle", 64'(a_armed), 64'd0);
    a_en = 1'b1;

    // exceptions pass unchanged and do not count
    a_set(ret(64'h600), 1'b1, '0, 1'b0, 2'b01);
    tick();
    e = addi(64'h604); e.ex.valid = 1'b1; e.ex.cause = 64'd5;
    a_set(e, 1'b1, '0, 1'b0, 2'b01);
    chk_e("exc_pass", a_out[0], e);
    tick();
    chk("exc_nocount", 64'(a_armed), 64'd1);
    a_set(mark(64'h608), 1'b1, '0, 1'b0, 2'b01);
    chk_e("exc_mark", a_out[0], mark(64'h608));
    tick();

    // a flagged return does not re-arm
    a_set(ret(64'h700), 1'b1, '0, 1'b0, 2'b01);
    tick();
    a_set(ret(64'h704), 1'b1, '0, 1'b0, 2'b01);
    chk_e("rr_flag", a_out[0], flagged(ret(64'h704)));
    tick();
    a_viol++; a_last = 64'h704;
    chk("rr_idle", 64'(a_armed), 64'd0);
    chk("rr_pc", a_pc, exp_pc(a_last));

    // reset in the middle of a window
    a_set(ret(64'h800), 1'b1, '0, 1'b0, 2'b01);
    tick();
    chk("rm_armed", 64'(a_armed), 64'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rm_async", 64'(a_armed), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    a_viol = 0; a_last = '0;
    a_set(addi(64'h804), 1'b1, '0, 1'b0, 2'b01);
    chk_e("rm_noflag", a_out[0], addi(64'h804));
    tick();
    chk("rm_cnt", 64'(a_cnt), exp_cnt(a_viol));

    // WINDOW=3: marker on the third follower
    b_set(ret(64'h1000), 1'b1, '0, 1'b0, 2'b01);
    tick();
    b_set(addi(64'h1004), 1'b1, '0, 1'b0, 2'b01);
    chk_e("w3_n1", b_out[0], addi(64'h1004));
    tick();
    b_set(addi(64'h1008), 1'b1, '0, 1'b0, 2'b01);
    chk_e("w3_n2", b_out[0], addi(64'h1008));
    tick();
    chk("w3_armed", 64'(b_armed), 64'd1);
    b_set(mark(64'h100c), 1'b1, '0, 1'b0, 2'b01);
    chk_e("w3_mark", b_out[0], mark(64'h100c));
    tick();
    chk("w3_idle", 64'(b_armed), 64'd0);

    // WINDOW=3: third follower is not a marker
    b_set(ret(64'h1110), 1'b1, '0, 1'b0, 2'b01);
    tick();
    b_set(addi(64'h1114), 1'b1, '0, 1'b0, 2'b01);
    tick();
    b_set(addi(64'h1118), 1'b1, '0, 1'b0, 2'b01);
    tick();
    b_set(addi(64'h111c), 1'b1, '0, 1'b0, 2'b01);
    chk_e("w3_flag", b_out[0], flagged(addi(64'h111c)));
    tick();
    b_viol++; b_last = 64'h111c;
    chk("w3_fidle", 64'(b_armed), 64'd0);

    // WINDOW=3 chained across ports
    b_set(ret(64'h1200), 1'b1, addi(64'h1204), 1'b1, 2'b11);
    chk_e("ch_p1", b_out[1], addi(64'h1204));
    tick();
    b_set(addi(64'h1208), 1'b1, addi(64'h120c), 1'b1, 2'b11);
    chk_e("ch_p0", b_out[0], addi(64'h1208));
    chk_e("ch_flag", b_out[1], flagged(addi(64'h120c)));
    tick();
    b_viol++; b_last = 64'h120c;
    chk("ch_idle", 64'(b_armed), 64'd0);

    // WINDOW=3: unacked cycles do not use up the window
    b_set(ret(64'h1300), 1'b1, '0, 1'b0, 2'b01);
    tick();
    for (int i = 0; i < 5; i++) begin
      b_set(addi(64'h1304), 1'b1, '0, 1'b0, 2'b00);
      tick();
    end
    chk("sw_armed", 64'(b_armed), 64'd1);
    b_set(addi(64'h1304), 1'b1, '0, 1'b0, 2'b01);
    chk_e("sw_n1", b_out[0], addi(64'h1304));
    tick();
    b_set(addi(64'h1308), 1'b1, '0, 1'b0, 2'b01);
    chk_e("sw_n2", b_out[0], addi(64'h1308));
    tick();
    b_set(mark(64'h130c), 1'b1, '0, 1'b0, 2'b01);
    chk_e("sw_mark", b_out[0], mark(64'h130c));
    tick();
    chk("sw_idle", 64'(b_armed), 64'd0);

    // WINDOW=3: a return inside the window reloads it
    b_set(ret(64'h1400), 1'b1, addi(64'h1404), 1'b1, 2'b11);
    tick();
    b_set(ret(64'h1408), 1'b1, addi(64'h140c), 1'b1, 2'b11);
    chk_e("rl_p0", b_out[0], ret(64'h1408));
    chk_e("rl_p1", b_out[1], addi(64'h140c));
    tick();
    b_set(addi(64'h1410), 1'b1, '0, 1'b0, 2'b01);
    chk_e("rl_n", b_out[0], addi(64'h1410));
    tick();
    b_set(mark(64'h1414), 1'b1, '0, 1'b0, 2'b01);
    chk_e("rl_mark", b_out[0], mark(64'h1414));
    tick();
    chk("rl_idle", 64'(b_armed), 64'd0);
    chk("b_cnt", 64'(b_cnt), exp_cnt(b_viol));
    chk("b_pc", b_pc, exp_pc(b_last));
    b_set('0, 1'b0, '0, 1'b0, 2'b00);

    // counter saturation: one violation per cycle
    a_set(ret(64'h900), 1'b1, addi(64'h904), 1'b1, 2'b11);
    while (a_viol < 65535) begin
      tick();
      a_viol++;
    end
    a_last = 64'h904;
    chk("sat_full", 64'(a_cnt), exp_cnt(a_viol));
    tick();
    a_viol++;
    chk("sat_hold", 64'(a_cnt), exp_cnt(a_viol));
    chk("sat_pc", a_pc, exp_pc(a_last));
    x = flagged(addi(64'h904));
    chk_e("sat_flag", a_out[1], x);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
